// File: rtl/genius_unidade_controle_param.sv
// -----------------------------------------------------------------------------
// genius_unidade_controle_param
//
// Control unit for the "Genius" memory game. It plays the stored sequence on
// the LEDs, waits for the player to repeat it and grows the sequence one step
// per round. It ends on a full correct game, a wrong press or a move timeout.
// The unit keeps its own counters and a single shared timer. The game
// sequence comes from an external ROM addressed by the current position.
//
// Optional feature: define GENIUS_VIDAS_EN to add lives. With lives enabled,
// an error or a timeout that leaves at least one life replays the current
// round instead of ending the game.
//
// Ports:
//   clock        system clock
//   reset        synchronous, active-high reset
//   jogar        start/restart request (level-sampled)
//   nivel        difficulty, latched when a game starts (0 half, 1 full length)
//   botoes       player buttons, active-high
//   memoria      ROM data at endereco (combinational, same cycle)
//   endereco     ROM address (current position in the sequence)
//   leds         sequence LED being shown, zero outside the show phase
//   pronto       game finished
//   ganhou       game finished with the whole sequence correct
//   perdeu       game finished by a wrong press or a timeout
//   deu_timeout  game finished by a timeout
//   db_estado    current FSM state code
//   db_rodada    current round (last position of the sequence in play)
//   db_vidas     remaining lives (0 when lives are disabled)
// -----------------------------------------------------------------------------
module genius_unidade_controle_param #(
   parameter int N_BOTOES  = 4,
   parameter int ADDR_W    = 4,
   parameter int T_LED     = 1000,
   parameter int T_APAGADO = 500,
   parameter int T_JOGADA  = 5000,
   parameter int VIDAS     = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                jogar,
   input  logic                nivel,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic [N_BOTOES-1:0] memoria,
   output logic [ADDR_W-1:0]   endereco,
   output logic [N_BOTOES-1:0] leds,
   output logic                pronto,
   output logic                ganhou,
   output logic                perdeu,
   output logic                deu_timeout,
   output logic [3:0]          db_estado,
   output logic [ADDR_W-1:0]   db_rodada,
   output logic [1:0]          db_vidas
);

   // The timer is shared by the show, gap and move phases, so it is sized
   // for the longest of them.
   localparam int T_MAX_1 = (T_LED > T_APAGADO) ? T_LED : T_APAGADO;
   localparam int T_MAX   = (T_MAX_1 > T_JOGADA) ? T_MAX_1 : T_JOGADA;
   localparam int TW      = (T_MAX > 1) ? $clog2(T_MAX) : 1;

   localparam logic [TW-1:0] FIM_LED     = TW'(T_LED - 1);
   localparam logic [TW-1:0] FIM_APAGADO = TW'(T_APAGADO - 1);
   localparam logic [TW-1:0] FIM_JOGADA  = TW'(T_JOGADA - 1);

   localparam logic [ADDR_W-1:0] LIM_CHEIO = ADDR_W'((2 ** ADDR_W) - 1);
   localparam logic [ADDR_W-1:0] LIM_MEIO  = ADDR_W'((2 ** (ADDR_W - 1)) - 1);

   // Lives are reported on a 2-bit debug port.
   if (VIDAS < 1 || VIDAS > 3) begin : g_vidas_invalida
      $error("VIDAS must be between 1 and 3");
   end

   typedef enum logic [3:0] {
      INICIAL       = 4'h0,
      PREPARACAO    = 4'h1,
      NOVA_SEQ      = 4'h2,
      ESPERA        = 4'h3,
      REGISTRA      = 4'h4,
      COMPARA       = 4'h5,
      PROXIMO       = 4'h6,
      APAGADO       = 4'h7,
`ifdef GENIUS_VIDAS_EN
      PERDE_VIDA    = 4'h8,
`endif
      FIM_ACERTO    = 4'hA,
      MOSTRA        = 4'hB,
      INICIA_RODADA = 4'hD,
      FIM_ERRO      = 4'hE,
      FIM_TIMEOUT   = 4'hF
   } estado_t;

   estado_t estado, estado_prox;

   logic [ADDR_W-1:0]   cont_e;
   logic [ADDR_W-1:0]   cont_s;
   logic [TW-1:0]       timer;
   logic [N_BOTOES-1:0] jogada_reg;
   logic [N_BOTOES-1:0] botoes_d;
   logic                nivel_reg;

   logic zera_timer, inc_timer;
   logic zera_cont_e, inc_cont_e;
   logic zera_cont_s, inc_cont_s;
   logic grava_jogada, grava_nivel;

`ifdef GENIUS_VIDAS_EN
   logic [1:0] vidas;
   logic       carrega_vidas, dec_vidas;
`endif

   // A press is the first cycle with any button down after a cycle with none,
   // so holding a button counts once.
   logic tem_jogada;
   assign tem_jogada = (|botoes) & ~(|botoes_d);

   logic [ADDR_W-1:0] limite;
   assign limite = nivel_reg ? LIM_CHEIO : LIM_MEIO;

   logic acertou;
   assign acertou = (jogada_reg == memoria);

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) estado <= INICIAL;
      else       estado <= estado_prox;
   end

   // ---------------------------------------------------------------------------
   // Next state and datapath strobes
   // ---------------------------------------------------------------------------
   always_comb begin
      estado_prox  = estado;
      zera_timer   = 1'b0;
      inc_timer    = 1'b0;
      zera_cont_e  = 1'b0;
      inc_cont_e   = 1'b0;
      zera_cont_s  = 1'b0;
      inc_cont_s   = 1'b0;
      grava_jogada = 1'b0;
      grava_nivel  = 1'b0;
`ifdef GENIUS_VIDAS_EN
      carrega_vidas = 1'b0;
      dec_vidas     = 1'b0;
`endif

      case (estado)
         INICIAL: begin
            if (jogar) estado_prox = PREPARACAO;
         end

         PREPARACAO: begin
            grava_nivel = 1'b1;
            zera_cont_e = 1'b1;
            zera_cont_s = 1'b1;
            zera_timer  = 1'b1;
`ifdef GENIUS_VIDAS_EN
            carrega_vidas = 1'b1;
`endif
            estado_prox = MOSTRA;
         end

         MOSTRA: begin
            if (timer == FIM_LED) begin
               zera_timer  = 1'b1;
               estado_prox = APAGADO;
            end else begin
               inc_timer = 1'b1;
            end
         end

         APAGADO: begin
            if (timer == FIM_APAGADO) begin
               zera_timer = 1'b1;
               if (cont_e == cont_s) begin
                  estado_prox = INICIA_RODADA;
               end else begin
                  inc_cont_e  = 1'b1;
                  estado_prox = MOSTRA;
               end
            end else begin
               inc_timer = 1'b1;
            end
         end

         INICIA_RODADA: begin
            zera_cont_e = 1'b1;
            zera_timer  = 1'b1;
            estado_prox = ESPERA;
         end

         ESPERA: begin
            inc_timer = 1'b1;
            // A press on the last allowed cycle still counts as a move.
            if (tem_jogada) begin
               grava_jogada = 1'b1;
               estado_prox  = REGISTRA;
            end else if (timer == FIM_JOGADA) begin
`ifdef GENIUS_VIDAS_EN
               estado_prox = (vidas > 2'd1) ? PERDE_VIDA : FIM_TIMEOUT;
`else
               estado_prox = FIM_TIMEOUT;
`endif
            end
         end

         // Gives the ROM a full cycle at the current address before comparing.
         REGISTRA: begin
            estado_prox = COMPARA;
         end

         COMPARA: begin
            if (!acertou) begin
`ifdef GENIUS_VIDAS_EN
               estado_prox = (vidas > 2'd1) ? PERDE_VIDA : FIM_ERRO;
`else
               estado_prox = FIM_ERRO;
`endif
            end else if (cont_e < cont_s) begin
               estado_prox = PROXIMO;
            end else if ((cont_e == cont_s) && (cont_s == limite)) begin
               estado_prox = FIM_ACERTO;
            end else begin
               estado_prox = NOVA_SEQ;
            end
         end

         PROXIMO: begin
            inc_cont_e  = 1'b1;
            zera_timer  = 1'b1;
            estado_prox = ESPERA;
         end

         NOVA_SEQ: begin
            inc_cont_s  = 1'b1;
            zera_cont_e = 1'b1;
            zera_timer  = 1'b1;
            estado_prox = MOSTRA;
         end

`ifdef GENIUS_VIDAS_EN
         // Replays the same round: cont_s is left untouched.
         PERDE_VIDA: begin
            dec_vidas   = 1'b1;
            zera_cont_e = 1'b1;
            zera_timer  = 1'b1;
            estado_prox = MOSTRA;
         end
`endif

         FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: begin
            if (jogar) estado_prox = PREPARACAO;
         end

         default: estado_prox = INICIAL;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         cont_e     <= '0;
         cont_s     <= '0;
         timer      <= '0;
         jogada_reg <= '0;
         botoes_d   <= '0;
         nivel_reg  <= 1'b0;
      end else begin
         botoes_d <= botoes;

         if (zera_timer)     timer <= '0;
         else if (inc_timer) timer <= timer + TW'(1);

         if (zera_cont_e)     cont_e <= '0;
         else if (inc_cont_e) cont_e <= cont_e + ADDR_W'(1);

         if (zera_cont_s)     cont_s <= '0;
         else if (inc_cont_s) cont_s <= cont_s + ADDR_W'(1);

         if (grava_jogada) jogada_reg <= botoes;
         if (grava_nivel)  nivel_reg  <= nivel;
      end
   end

`ifdef GENIUS_VIDAS_EN
   always_ff @(posedge clock) begin
      if (reset)              vidas <= 2'd0;
      else if (carrega_vidas) vidas <= 2'(VIDAS);
      else if (dec_vidas)     vidas <= vidas - 2'd1;
   end

   assign db_vidas = vidas;
`else
   assign db_vidas = 2'd0;
`endif

   // ---------------------------------------------------------------------------
   // Moore outputs
   // ---------------------------------------------------------------------------
   assign endereco    = cont_e;
   assign db_rodada   = cont_s;
   assign db_estado   = estado;
   assign leds        = (estado == MOSTRA) ? memoria : '0;
   assign ganhou      = (estado == FIM_ACERTO);
   assign perdeu      = (estado == FIM_ERRO) || (estado == FIM_TIMEOUT);
   assign deu_timeout = (estado == FIM_TIMEOUT);
   assign pronto      = ganhou || perdeu;

endmodule

// File: tb/tb_genius_unidade_controle_param.sv
// -----------------------------------------------------------------------------
// Bench for genius_unidade_controle_param with a small configuration:
// 4 buttons, 2-bit addresses, T_LED=4, T_APAGADO=2, T_JOGADA=10, and the
// ROM {0001,0010,0100,1000}. Inputs change on the falling edge and outputs
// are sampled on the falling edge. Every task starts and ends on a falling
// edge.
// -----------------------------------------------------------------------------
module tb_genius_unidade_controle_param;

   localparam logic [3:0] S_INICIAL    = 4'h0;
   localparam logic [3:0] S_PREPARACAO = 4'h1;
   localparam logic [3:0] S_ESPERA     = 4'h3;
   localparam logic [3:0] S_APAGADO    = 4'h7;
   localparam logic [3:0] S_FIM_ACERTO = 4'hA;
   localparam logic [3:0] S_MOSTRA     = 4'hB;
   localparam logic [3:0] S_FIM_ERRO   = 4'hE;
   localparam logic [3:0] S_FIM_TIMEOUT = 4'hF;
`ifdef GENIUS_VIDAS_EN
   localparam logic [3:0] S_PERDE_VIDA = 4'h8;
`endif

   // ---------------------------------------------------------------------------
   // Clock and reset
   // ---------------------------------------------------------------------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic       jogar = 1'b0;
   logic       nivel = 1'b0;
   logic [3:0] botoes = 4'b0000;
   logic [3:0] memoria;
   logic [1:0] endereco;
   logic [3:0] leds;
   logic       pronto, ganhou, perdeu, deu_timeout;
   logic [3:0] db_estado;
   logic [1:0] db_rodada;
   logic [1:0] db_vidas;

   logic [3:0] rom [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
   assign memoria = rom[endereco];

   genius_unidade_controle_param #(
      .N_BOTOES (4),
      .ADDR_W   (2),
      .T_LED    (4),
      .T_APAGADO(2),
      .T_JOGADA (10),
      .VIDAS    (2)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .jogar      (jogar),
      .nivel      (nivel),
      .botoes     (botoes),
      .memoria    (memoria),
      .endereco   (endereco),
      .leds       (leds),
      .pronto     (pronto),
      .ganhou     (ganhou),
      .perdeu     (perdeu),
      .deu_timeout(deu_timeout),
      .db_estado  (db_estado),
      .db_rodada  (db_rodada),
      .db_vidas   (db_vidas)
   );

   // ---------------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
   endtask

   // ---------------------------------------------------------------------------
   // Driver tasks
   // ---------------------------------------------------------------------------
   task automatic wait_estado(input string tag, input logic [3:0] code, input int budget);
      int n;
      n = 0;
      while (db_estado !== code && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, 32'(db_estado), 32'(code));
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      jogar  = 1'b0;
      nivel  = 1'b0;
      botoes = 4'b0000;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic start_game(input logic nv);
      nivel = nv;
      jogar = 1'b1;
      @(negedge clock);
      jogar = 1'b0;
      check("start_preparacao", 32'(db_estado), 32'(S_PREPARACAO));
   endtask

   // Watches the show phase of round r: positions 0..r in order.
   task automatic show_round(input int r);
      for (int k = 0; k <= r; k++) exp_q.push_back(rom[k]);
      for (int k = 0; k <= r; k++) begin
         wait_estado("wait_mostra", S_MOSTRA, 12);
         check("leds_mostra", 32'(leds), 32'(exp_q.pop_front()));
         check("endereco_mostra", 32'(endereco), 32'(k));
         check("rodada_mostra", 32'(db_rodada), 32'(r));
         wait_estado("wait_apagado", S_APAGADO, 8);
         check("leds_apagado", 32'(leds), 32'd0);
      end
   endtask

   task automatic press(input logic [3:0] b);
      botoes = b;
      @(negedge clock);
      botoes = 4'b0000;
      @(negedge clock);
   endtask

   task automatic play_round(input int r);
      for (int k = 0; k <= r; k++) begin
         wait_estado("wait_espera", S_ESPERA, 12);
         press(rom[k]);
      end
   endtask

   // Waits out a whole move window: still waiting after 9 cycles, gone after 10.
   task automatic time_out(input logic [3:0] next_code);
      wait_estado("wait_espera_to", S_ESPERA, 12);
      repeat (9) @(negedge clock);
      check("espera_before_to", 32'(db_estado), 32'(S_ESPERA));
      @(negedge clock);
      check("estado_after_to", 32'(db_estado), 32'(next_code));
   endtask

   // ---------------------------------------------------------------------------
   // Watchdog
   // ---------------------------------------------------------------------------
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      @(negedge clock);
      do_reset();

      // Reset state
      check("rst_estado", 32'(db_estado), 32'(S_INICIAL));
      check("rst_leds", 32'(leds), 32'd0);
      check("rst_pronto", 32'(pronto), 32'd0);
      check("rst_ganhou", 32'(ganhou), 32'd0);
      check("rst_perdeu", 32'(perdeu), 32'd0);
      check("rst_timeout", 32'(deu_timeout), 32'd0);
      check("rst_endereco", 32'(endereco), 32'd0);
      check("rst_rodada", 32'(db_rodada), 32'd0);
      check("rst_vidas", 32'(db_vidas), 32'd0);

      // Half-length game, all correct
      start_game(1'b0);
      show_round(0);
      play_round(0);
      show_round(1);
      play_round(1);
      wait_estado("half_fim_acerto", S_FIM_ACERTO, 12);
      check("half_ganhou", 32'(ganhou), 32'd1);
      check("half_pronto", 32'(pronto), 32'd1);
      check("half_perdeu", 32'(perdeu), 32'd0);

      // Full-length game, all correct, restarted from the end state
      start_game(1'b1);
      for (int r = 0; r < 4; r++) begin
         show_round(r);
         play_round(r);
      end
      wait_estado("full_fim_acerto", S_FIM_ACERTO, 12);
      check("full_rodada", 32'(db_rodada), 32'd3);
      check("full_ganhou", 32'(ganhou), 32'd1);

      // Wrong press in the first round
      do_reset();
      start_game(1'b0);
      show_round(0);
      wait_estado("err_espera", S_ESPERA, 12);
      press(4'b0100);
`ifdef GENIUS_VIDAS_EN
      wait_estado("err_perde_vida", S_PERDE_VIDA, 4);
      show_round(0);
      check("err_vidas", 32'(db_vidas), 32'd1);
      wait_estado("err_espera2", S_ESPERA, 12);
      press(4'b0100);
`endif
      wait_estado("err_fim_erro", S_FIM_ERRO, 4);
      check("err_perdeu", 32'(perdeu), 32'd1);
      check("err_pronto", 32'(pronto), 32'd1);
      check("err_ganhou", 32'(ganhou), 32'd0);
      check("err_timeout", 32'(deu_timeout), 32'd0);
      check("err_endereco", 32'(endereco), 32'd0);

      // No press during the move window
      start_game(1'b0);
      show_round(0);
`ifdef GENIUS_VIDAS_EN
      time_out(S_PERDE_VIDA);
      show_round(0);
      check("to_vidas", 32'(db_vidas), 32'd1);
`endif
      time_out(S_FIM_TIMEOUT);
      check("to_deu_timeout", 32'(deu_timeout), 32'd1);
      check("to_perdeu", 32'(perdeu), 32'd1);
      check("to_pronto", 32'(pronto), 32'd1);
      jogar = 1'b1;
      @(negedge clock);
      jogar = 1'b0;
      check("to_restart", 32'(db_estado), 32'(S_PREPARACAO));

      // Held button in the second round counts once
      do_reset();
      start_game(1'b1);
      show_round(0);
      play_round(0);
      show_round(1);
      wait_estado("hold_espera", S_ESPERA, 12);
      botoes = rom[0];
      repeat (8) @(negedge clock);
      check("hold_endereco", 32'(endereco), 32'd1);
      check("hold_estado", 32'(db_estado), 32'(S_ESPERA));
      botoes = 4'b0000;
      @(negedge clock);
      press(rom[1]);
      wait_estado("hold_mostra", S_MOSTRA, 12);
      check("hold_rodada", 32'(db_rodada), 32'd2);
      check("hold_leds", 32'(leds), 32'(rom[0]));

      // Reset while showing the sequence
      reset = 1'b1;
      @(negedge clock);
      check("midrst_estado", 32'(db_estado), 32'(S_INICIAL));
      check("midrst_leds", 32'(leds), 32'd0);
      check("midrst_endereco", 32'(endereco), 32'd0);
      check("midrst_rodada", 32'(db_rodada), 32'd0);
      reset = 1'b0;
      @(negedge clock);

      // Final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
